// File: rtl/packetizer_rr_arbiter.sv
// packetizer_rr_arbiter
// Shares one queue-insertion port between NUMBER_OF_INPUTS packetizers.
// A round-robin grant picks one requesting input per cycle. The accepted
// packet and its destination queue id are captured in a one-entry output
// register, so the queue-side timing is decoupled from the packetizer side.
// Back-to-back transfers reach one packet per cycle because the register
// can reload on the same edge that drains it.

module packetizer_rr_arbiter #(
   parameter  int DATA_SIZE        = 512,
   parameter  int NUMBER_OF_QUEUES = 4,
   parameter  int NUMBER_OF_INPUTS = 2,
   localparam int QW = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1,
   localparam int IW = $clog2(NUMBER_OF_INPUTS)
) (
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic [NUMBER_OF_INPUTS-1:0]           inputs_enable,
   input  logic [NUMBER_OF_INPUTS-1:0]           packetizers_valid,
   output logic [NUMBER_OF_INPUTS-1:0]           packetizers_ready,
   input  logic [NUMBER_OF_INPUTS*QW-1:0]        packetizers_id,
   input  logic [NUMBER_OF_INPUTS*DATA_SIZE-1:0] packetizers_packet,
   output logic                                  queues_valid,
   input  logic                                  queues_ready,
   output logic [QW-1:0]                         queues_id,
   output logic [DATA_SIZE-1:0]                  queues_packet,
   output logic [IW-1:0]                         last_grant
);

   // Priority pointer value after reset: the last input, so input 0 wins first.
   localparam logic [IW-1:0] LAST_INPUT = IW'(NUMBER_OF_INPUTS - 1);

   // Registered state
   logic                           queues_valid_q;
   logic                           queues_valid_d;
   logic [QW-1:0]                  queues_id_q;
   logic [QW-1:0]                  queues_id_d;
   logic [DATA_SIZE-1:0]           queues_packet_q;
   logic [DATA_SIZE-1:0]           queues_packet_d;
   logic [IW-1:0]                  last_grant_q;
   logic [IW-1:0]                  last_grant_d;

   // Arbitration and handshake signals
   logic [NUMBER_OF_INPUTS-1:0]    req_s;
   logic [NUMBER_OF_INPUTS-1:0]    grant_s;
   logic [IW-1:0]                  grant_idx_s;
   logic [NUMBER_OF_INPUTS-1:0]    ready_s;
   logic [QW-1:0]                  sel_id_s;
   logic [DATA_SIZE-1:0]           sel_packet_s;
   logic                           can_load_s;
   logic                           in_hs_s;
   logic                           out_hs_s;

   // Index reached by stepping 'offset' places past 'base', wrapping modulo
   // the input count. The sum is one bit wider than an index, and since
   // base < N and offset <= N a single conditional subtraction is enough.
   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base,
                                              input int            offset);
      logic [IW:0] sum;
      sum = {1'b0, base} + (IW+1)'(offset);
      if (sum >= (IW+1)'(NUMBER_OF_INPUTS)) begin
         sum = sum - (IW+1)'(NUMBER_OF_INPUTS);
      end else begin
         sum = sum;
      end
      return sum[IW-1:0];
   endfunction

   // A disabled input never requests, whatever its valid says.
   assign req_s = packetizers_valid & inputs_enable;

   // Round-robin search starting just after the last accepted input.
   always_comb begin
      logic [IW-1:0] cand_v;
      logic          found_v;
      grant_s     = '0;
      grant_idx_s = last_grant_q;
      found_v     = 1'b0;
      cand_v      = '0;
      for (int k = 1; k <= NUMBER_OF_INPUTS; k++) begin
         cand_v = rr_index(last_grant_q, k);
         if (!found_v && req_s[cand_v]) begin
            grant_s[cand_v] = 1'b1;
            grant_idx_s     = cand_v;
            found_v         = 1'b1;
         end else begin
            found_v = found_v;
         end
      end
   end

   // One-hot AND-OR mux of the granted input's id and packet.
   always_comb begin
      sel_id_s     = '0;
      sel_packet_s = '0;
      for (int i = 0; i < NUMBER_OF_INPUTS; i++) begin
         sel_id_s     = sel_id_s
                      | (packetizers_id[i*QW +: QW] & {QW{grant_s[i]}});
         sel_packet_s = sel_packet_s
                      | (packetizers_packet[i*DATA_SIZE +: DATA_SIZE]
                         & {DATA_SIZE{grant_s[i]}});
      end
   end

   // The output register can take a packet when it is empty or draining now.
   // Ready is also held low while reset is asserted.
   assign can_load_s = ~queues_valid_q | queues_ready;
   assign ready_s    = grant_s & {NUMBER_OF_INPUTS{can_load_s & aresetn}};
   assign in_hs_s    = |(ready_s & packetizers_valid);
   assign out_hs_s   = queues_valid_q & queues_ready;

   // Next state of the output register and the priority pointer.
   always_comb begin
      queues_valid_d  = queues_valid_q;
      queues_id_d     = queues_id_q;
      queues_packet_d = queues_packet_q;
      last_grant_d    = last_grant_q;
      if (in_hs_s) begin
         // Load, possibly replacing a packet that drains on this same edge.
         queues_valid_d  = 1'b1;
         queues_id_d     = sel_id_s;
         queues_packet_d = sel_packet_s;
         last_grant_d    = grant_idx_s;
      end else if (out_hs_s) begin
         // Drained with nothing to replace it: id and packet keep old values.
         queues_valid_d  = 1'b0;
      end else begin
         // Idle, stalled or withdrawn request: nothing moves.
         queues_valid_d  = queues_valid_q;
      end
   end

   // State registers; asynchronous reset discards any buffered packet.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         queues_valid_q  <= 1'b0;
         queues_id_q     <= '0;
         queues_packet_q <= '0;
         last_grant_q    <= LAST_INPUT;
      end else begin
         queues_valid_q  <= queues_valid_d;
         queues_id_q     <= queues_id_d;
         queues_packet_q <= queues_packet_d;
         last_grant_q    <= last_grant_d;
      end
   end

   assign packetizers_ready = ready_s;
   assign queues_valid      = queues_valid_q;
   assign queues_id         = queues_id_q;
   assign queues_packet     = queues_packet_q;
   assign last_grant        = last_grant_q;

endmodule

// File: tb/tb_packetizer_rr_arbiter.sv
// Bench for packetizer_rr_arbiter with four inputs: a directed table,
// hand-written corner sequences and a randomized run against a reference model.

module tb_packetizer_rr_arbiter;

   localparam int N  = 4;
   localparam int NQ = 4;
   localparam int DW = 32;
   localparam int QW = 2;
   localparam int IW = 2;

   logic            aclk;
   logic            aresetn;
   logic [N-1:0]    en;
   logic [N-1:0]    valid;
   logic [N-1:0]    ready;
   logic [N*QW-1:0] ids;
   logic [N*DW-1:0] pkts;
   logic            qv;
   logic            qr;
   logic [QW-1:0]   qid;
   logic [DW-1:0]   qpkt;
   logic [IW-1:0]   lgrant;

   logic [QW-1:0]   id_a  [N];
   logic [DW-1:0]   pkt_a [N];

   int nvec;
   int nerr;

   // Reference model state
   bit              m_valid;
   int              m_id;
   logic [DW-1:0]   m_pkt;
   int              m_last;

   typedef struct {
      logic [N-1:0]  valid;
      logic [N-1:0]  en;
      logic          qr;
      logic [N-1:0]  exp_ready;
      logic          exp_qv;
      logic [QW-1:0] exp_id;
      logic [DW-1:0] exp_pkt;
      logic [IW-1:0] exp_last;
   } vec_t;

   vec_t tbl [16];

   packetizer_rr_arbiter #(
      .DATA_SIZE        (DW),
      .NUMBER_OF_QUEUES (NQ),
      .NUMBER_OF_INPUTS (N)
   ) dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .inputs_enable      (en),
      .packetizers_valid  (valid),
      .packetizers_ready  (ready),
      .packetizers_id     (ids),
      .packetizers_packet (pkts),
      .queues_valid       (qv),
      .queues_ready       (qr),
      .queues_id          (qid),
      .queues_packet      (qpkt),
      .last_grant         (lgrant)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Pack the per-input arrays onto the DUT buses.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         ids[i*QW +: QW]  = id_a[i];
         pkts[i*DW +: DW] = pkt_a[i];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called just after a rising edge with inputs set: checks ready mid-cycle,
   // clocks once, then checks the registered outputs.
   task automatic cycle(input string name, input logic [N-1:0] e_ready, input logic e_qv,
                        input logic [QW-1:0] e_id, input logic [DW-1:0] e_pkt,
                        input logic [IW-1:0] e_last);
      #3;
      chk({name, ".ready"}, 64'(ready), 64'(e_ready));
      @(posedge aclk);
      #1;
      chk({name, ".qv"},   64'(qv),     64'(e_qv));
      chk({name, ".id"},   64'(qid),    64'(e_id));
      chk({name, ".pkt"},  64'(qpkt),   64'(e_pkt));
      chk({name, ".last"}, 64'(lgrant), 64'(e_last));
   endtask

   // Reference grant: first requester after m_last in cyclic order, or -1.
   function automatic int model_grant();
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (m_last + k) % N;
         if (valid[idx] && en[idx]) return idx;
      end
      return -1;
   endfunction

   initial begin
      nvec = 0;
      nerr = 0;
      for (int i = 0; i < N; i++) begin
         id_a[i]  = QW'(i);
         pkt_a[i] = 32'hA0 + DW'(i);
      end

      tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA0, 2'd0};
      tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA1, 2'd1};
      tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'hA2, 2'd2};
      tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA3, 2'd3};
      tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA0, 2'd0};
      tbl[5]  = '{4'hF, 4'hA, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA1, 2'd1};
      tbl[6]  = '{4'hF, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA3, 2'd3};
      tbl[7]  = '{4'hF, 4'hA, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA1, 2'd1};
      tbl[8]  = '{4'hF, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA3, 2'd3};
      tbl[9]  = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd3, 32'hA3, 2'd3};
      tbl[10] = '{4'h4, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'hA2, 2'd2};
      tbl[11] = '{4'h4, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 32'hA2, 2'd2};
      tbl[12] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 32'hA2, 2'd2};
      tbl[13] = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA3, 2'd3};
      tbl[14] = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 32'hA3, 2'd3};
      tbl[15] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd3, 32'hA3, 2'd3};

      // Reset state, with every input requesting to show ready is gated.
      aresetn = 1'b0;
      valid   = 4'hF;
      en      = 4'hF;
      qr      = 1'b1;
      #12;
      chk("rst.ready", 64'(ready),  64'h0);
      chk("rst.qv",    64'(qv),     64'h0);
      chk("rst.id",    64'(qid),    64'h0);
      chk("rst.pkt",   64'(qpkt),   64'h0);
      chk("rst.last",  64'(lgrant), 64'h3);
      @(posedge aclk);
      #1;
      valid   = 4'h0;
      aresetn = 1'b1;

      // Directed table: rotation, enable mask, drain, stall.
      for (int r = 0; r < 16; r++) begin
         valid = tbl[r].valid;
         en    = tbl[r].en;
         qr    = tbl[r].qr;
         cycle($sformatf("tbl%0d", r), tbl[r].exp_ready, tbl[r].exp_qv,
               tbl[r].exp_id, tbl[r].exp_pkt, tbl[r].exp_last);
      end

      // Sole requester: input 2, id 3, packet 0x55, every cycle.
      id_a[2]  = 2'd3;
      pkt_a[2] = 32'h55;
      valid    = 4'h4;
      en       = 4'hF;
      qr       = 1'b1;
      for (int c = 0; c < 5; c++) cycle("sole", 4'h4, 1'b1, 2'd3, 32'h55, 2'd2);

      // Stall holding 0x11 while all inputs request.
      id_a[0]  = 2'd1;
      pkt_a[0] = 32'h11;
      valid    = 4'h1;
      cycle("stall.load", 4'h1, 1'b1, 2'd1, 32'h11, 2'd0);
      valid = 4'hF;
      qr    = 1'b0;
      for (int c = 0; c < 4; c++) cycle("stall.hold", 4'h0, 1'b1, 2'd1, 32'h11, 2'd0);
      qr = 1'b1;
      cycle("stall.release", 4'h2, 1'b1, 2'd1, 32'hA1, 2'd1);

      // Withdrawal: input 1 requests during a stall, then drops valid.
      valid = 4'h1;
      cycle("wd.pre", 4'h1, 1'b1, 2'd1, 32'h11, 2'd0);
      valid = 4'hA;
      qr    = 1'b0;
      cycle("wd.stall", 4'h0, 1'b1, 2'd1, 32'h11, 2'd0);
      valid = 4'h8;
      qr    = 1'b1;
      cycle("wd.take3", 4'h8, 1'b1, 2'd3, 32'hA3, 2'd3);
      valid = 4'h0;
      cycle("wd.drain", 4'h0, 1'b0, 2'd3, 32'hA3, 2'd3);

      // Reset while a packet is buffered.
      valid = 4'hF;
      qr    = 1'b0;
      cycle("mr.load", 4'h1, 1'b1, 2'd1, 32'h11, 2'd0);
      #1;
      aresetn = 1'b0;
      #1;
      chk("mr.qv",    64'(qv),     64'h0);
      chk("mr.ready", 64'(ready),  64'h0);
      chk("mr.pkt",   64'(qpkt),   64'h0);
      chk("mr.last",  64'(lgrant), 64'h3);
      #1;
      aresetn = 1'b1;
      qr      = 1'b1;
      cycle("mr.after", 4'h1, 1'b1, 2'd1, 32'h11, 2'd0);

      // Randomized run against the reference model, from a fresh reset.
      valid   = 4'h0;
      aresetn = 1'b0;
      #2;
      aresetn = 1'b1;
      m_valid = 1'b0;
      m_id    = 0;
      m_pkt   = '0;
      m_last  = N - 1;
      @(posedge aclk);
      #1;
      for (int c = 0; c < 400; c++) begin
         int           g;
         logic [N-1:0] e_ready;
         for (int i = 0; i < N; i++) begin
            id_a[i]  = QW'($urandom);
            pkt_a[i] = $urandom;
         end
         valid = N'($urandom);
         en    = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
         qr    = ($urandom_range(0, 3) != 0);
         #3;
         g       = model_grant();
         e_ready = ((!m_valid || qr) && g >= 0) ? N'(1 << g) : '0;
         chk("rnd.ready", 64'(ready), 64'(e_ready));
         if (e_ready != '0) begin
            m_valid = 1'b1;
            m_id    = int'(id_a[g]);
            m_pkt   = pkt_a[g];
            m_last  = g;
         end else if (m_valid && qr) begin
            m_valid = 1'b0;
         end
         @(posedge aclk);
         #1;
         chk("rnd.qv",   64'(qv),     64'(m_valid));
         chk("rnd.id",   64'(qid),    64'(m_id));
         chk("rnd.pkt",  64'(qpkt),   64'(m_pkt));
         chk("rnd.last", 64'(lgrant), 64'(m_last));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/packetizer_rr_arbiter.md
Name: packetizer_rr_arbiter

Overview:
- Shares the single queue-insertion port between NUMBER_OF_INPUTS packetizers.
- Uses a round-robin grant and a one-entry registered output stage, so queue-side timing is isolated from packetizer-side timing.
- Sits between the packetizers and the per-queue FIFO bank, and carries a packet plus its destination queue id.
- Supersedes the fixed-priority two-input mux: any number of inputs, fair service, full throughput.

Parameters:
- DATA_SIZE, 512, packet width in bits.
- NUMBER_OF_QUEUES, 4, number of destination queues. Id width is QW = $clog2(NUMBER_OF_QUEUES).
- NUMBER_OF_INPUTS, 2, number of packetizers (≥2). Index width is IW = $clog2(NUMBER_OF_INPUTS).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- inputs_enable  in  NUMBER_OF_INPUTS  per-input enable; a 0 bit means the input is never granted.
- packetizers_valid  in  NUMBER_OF_INPUTS  per-input packet valid.
- packetizers_ready  out  NUMBER_OF_INPUTS  per-input accept (one-hot or zero).
- packetizers_id  in  NUMBER_OF_INPUTS×QW  per-input destination queue id.
- packetizers_packet  in  NUMBER_OF_INPUTS×DATA_SIZE  per-input packet.
- queues_valid  out  1  output register holds a packet.
- queues_ready  in  1  queue side accepts.
- queues_id  out  QW  registered queue id.
- queues_packet  out  DATA_SIZE  registered packet.
- last_grant  out  IW  index of the most recently accepted input (status).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - queues_valid=0, queues_id=0, queues_packet=0.
  - last_grant=NUMBER_OF_INPUTS-1, so input 0 has first priority after reset.
  - packetizers_ready=0 while aresetn=0.
- Request vector: req = packetizers_valid & inputs_enable.
- Grant is purely combinational from req and last_grant:
  - Search order is last_grant+1, last_grant+2, … wrapping modulo NUMBER_OF_INPUTS.
  - The first set bit wins.
  - The grant is one-hot; it is zero when req=0.
- can_load = !queues_valid | queues_ready.
- packetizers_ready[i] = can_load & grant[i]. It does not depend on packetizers_valid[i] beyond arbitration.
- Input handshake: occurs on packetizers_valid[i] & packetizers_ready[i] at the rising edge. On that edge:
  - The output register loads packetizers_id[i] and packetizers_packet[i].
  - queues_valid<=1.
  - last_grant<=i.
- Output handshake: occurs on queues_valid & queues_ready.
  - If no input handshake happens in the same cycle, queues_valid<=0. id and packet hold their old values.
  - If an input handshake also happens in the same cycle, the register reloads. This gives back-to-back throughput of 1 packet/cycle.
- Stall (queues_valid=1, queues_ready=0):
  - All packetizers_ready=0.
  - queues_id and queues_packet are stable.
  - last_grant is unchanged.
- Latency: 1 cycle from input handshake to queues_valid=1.
- queues_valid must not drop without queues_ready.
- Fairness: under continuous requests from all N enabled inputs with queues_ready=1, each input is granted exactly once every N cycles.
- A sole requester is granted every cycle.
- inputs_enable may change any cycle; it takes effect on the combinational grant of that same cycle. A packet already in the output register is unaffected.
- A packetizer may drop valid before it is granted; this is a legal withdrawal and no state changes.
- last_grant only updates on an accepted handshake. A withdrawn or idle cycle leaves the priority pointer unchanged.
- Reset mid-operation: the buffered packet is discarded and queues_valid drops asynchronously. The packetizer must re-present its packet, because nothing was acknowledged on the queue side.

Test Plan:
- Reset, then N=4, all valid with distinct packets 0xA0..0xA3, queues_ready=1 → queues_packet sequence A0,A1,A2,A3,A0… one per cycle, first valid 1 cycle after the first ready.
- Input 2 only valid, id=3, packet 0x55, queues_ready=1 for 5 cycles → packetizers_ready=0b0100 every cycle, 5 outputs with id=3.
- Output holding 0x11, queues_ready=0 for 4 cycles while all inputs are valid → packetizers_ready=0, queues_packet stays 0x11, last_grant unchanged; on release the next input after last_grant is accepted on the same edge the output drains.
- inputs_enable=0b1010, all valid → grants alternate 1,3,1,3; inputs 0 and 2 never see ready.
- Input 1 asserts valid then withdraws before grant while input 3 is valid → input 3 is accepted, last_grant=3, no packet from input 1 appears.
- Assert aresetn=0 mid-stream with queues_valid=1 → queues_valid=0 immediately; after release, input 0 is granted first.
